mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
Shares the single data-memory port between the instruction fetch unit (IFU) and the load/store unit (LSU). It runs one transaction at a time through a four-state FSM and uses round-robin arbitration. Each requester gets a valid/ready request channel and a valid/ready response channel. A response timeout counter reports an error instead of letting a transaction hang.

Parameters:
DATA_W, 32, width of address, write-data and read-data buses
TIMEOUT, 255, maximum cycles in RESP waiting for mem_resp_valid before an error response (1..255)

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  asynchronous, active-low reset
ifu_req_valid  in  1  IFU read request pending
ifu_req_ready  out  1  IFU request accepted this cycle
ifu_addr  in  DATA_W  IFU read address
ifu_resp_valid  out  1  IFU response available
ifu_resp_ready  in  1  IFU consumes response
ifu_rdata  out  DATA_W  IFU read data
lsu_req_valid  in  1  LSU request pending
lsu_req_ready  out  1  LSU request accepted this cycle
lsu_addr  in  DATA_W  LSU address
lsu_wen  in  1  1 = write, 0 = read
lsu_wdata  in  DATA_W  LSU write data
lsu_wmask  in  4  LSU byte-enable mask
lsu_resp_valid  out  1  LSU response available (read data or write acknowledge)
lsu_resp_ready  in  1  LSU consumes response
lsu_rdata  out  DATA_W  LSU read data, 0 for writes
resp_err  out  1  timeout error, qualified by ifu_resp_valid or lsu_resp_valid
mem_req_valid  out  1  request to memory
mem_req_ready  in  1  memory accepts request
mem_addr  out  DATA_W  memory address
mem_wen  out  1  memory write enable
mem_wdata  out  DATA_W  memory write data
mem_wmask  out  4  memory byte mask, 4'b0000 for reads
mem_resp_valid  in  1  memory response
mem_resp_ready  out  1  arbiter accepts memory response
mem_rdata  in  DATA_W  memory read data

Behaviour:
- Reset (rst=0, asynchronous): state = IDLE; all valid/ready outputs 0; data outputs 0; resp_err 0; timeout counter 0; last_grant = LSU, so IFU wins the first tie. Any in-flight transaction is dropped and no response is issued.
- FSM states: IDLE, REQ, RESP, DELIVER.
- IDLE, owner selection: if only one requester is valid, that requester is the owner. If both are valid, the owner is the requester that is not last_grant.
- IDLE, grant actions: the owner's req_ready is 1 combinationally in the same cycle. Owner, addr, wen, wdata and wmask are captured into registers (IFU: wen=0, wmask=0). last_grant is updated. State goes to REQ. Only one req_ready is ever high at a time.
- REQ: mem_req_valid=1 and mem_* are driven from the captured registers, held stable until mem_req_ready=1. On that handshake: state goes to RESP and the counter clears. No timeout applies in REQ.
- RESP: mem_resp_ready=1; the counter increments each cycle.
  - If mem_resp_valid=1: capture rdata (forced to 0 for writes) with err=0, then go to DELIVER.
  - Else if counter == TIMEOUT-1: capture rdata=0 with err=1, then go to DELIVER.
  - If mem_resp_valid arrives in the same cycle as the timeout, mem_resp_valid wins.
- DELIVER: the owner's resp_valid=1, with its rdata and resp_err driven from registers. These hold until that owner's resp_ready=1, then state returns to IDLE. The non-owner's resp_valid is 0 and its rdata is 0. mem_resp_ready=0, so stray memory responses are not consumed.
- Minimum latency, request accept to resp_valid, with a zero-wait memory: 2 cycles (REQ and RESP cycles), with resp_valid asserted in the 3rd cycle.
- Back-to-back: there is no grant in the DELIVER→IDLE cycle. A new grant happens in IDLE the following cycle.
- Requests that drop valid before a grant are ignored; there is no internal queue.
- IFU write attempts are impossible by construction.

Test Plan:
- Reset, then IFU read of 0x8000_0000, memory returns 0x0000_0413 after 2 wait cycles -> ifu_req_ready pulses once; mem_addr = 0x8000_0000; mem_wmask = 0; ifu_rdata = 0x0000_0413; resp_err = 0; lsu_resp_valid stays 0.
- LSU write of 0xDEADBEEF to 0x8000_1000 with mask 4'b0011 -> mem_wen = 1; mem_wdata = 0xDEADBEEF; mem_wmask = 4'b0011; lsu_resp_valid = 1; lsu_rdata = 0.
- Both requesters held valid for 4 transactions -> grants go IFU, LSU, IFU, LSU; there are never two req_ready signals high in the same cycle.
- Memory never returns a response, with TIMEOUT = 8 -> exactly 8 cycles in RESP; the owner's resp_valid = 1 with resp_err = 1 and rdata = 0; the next request proceeds normally.
- mem_req_ready held 0 for 5 cycles -> mem_addr, mem_wdata and mem_wmask remain stable; no timeout occurs; the transaction completes after ready is asserted.
- rst pulled low during RESP -> all outputs are 0 immediately, without waiting for a clock edge; after release the FSM is in IDLE and a late mem_resp_valid is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one data-memory port between IFU (read-only) and LSU.
// One transaction in flight at a time; a RESP-phase timeout turns a lost memory response into an error response.
module mem_arbiter #(
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ifu_req_valid,
  output logic              ifu_req_ready,
  input  logic [DATA_W-1:0] ifu_addr,
  output logic              ifu_resp_valid,
  input  logic              ifu_resp_ready,
  output logic [DATA_W-1:0] ifu_rdata,
  input  logic              lsu_req_valid,
  output logic              lsu_req_ready,
  input  logic [DATA_W-1:0] lsu_addr,
  input  logic              lsu_wen,
  input  logic [DATA_W-1:0] lsu_wdata,
  input  logic [3:0]        lsu_wmask,
  output logic              lsu_resp_valid,
  input  logic              lsu_resp_ready,
  output logic [DATA_W-1:0] lsu_rdata,
  output logic              resp_err,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [DATA_W-1:0] mem_addr,
  output logic              mem_wen,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic              mem_resp_valid,
  output logic              mem_resp_ready,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int   NUM_REQ = 2;
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DELIVER} state_t;

  typedef struct packed {
    logic              owner;
    logic [DATA_W-1:0] addr;
    logic              wen;
    logic [DATA_W-1:0] wdata;
    logic [3:0]        wmask;
  } req_t;

  state_t                    state;
  req_t                      cur;
  req_t                      new_req;
  logic                      last_grant;
  logic [7:0]                tmo_cnt;
  logic [DATA_W-1:0]         rdata_q;
  logic                      err_q;
  logic                      mem_req_valid_q;
  logic                      mem_resp_ready_q;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_grant;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [NUM_REQ-1:0]        resp_valid_q;
  logic                      resp_done;

  assign req_valid  = {lsu_req_valid, ifu_req_valid};
  assign resp_ready = {lsu_resp_ready, ifu_resp_ready};

  // Grant is combinational so the winner sees req_ready in the cycle it asks;
  // gated by rst so nothing is acknowledged while reset is held.
  always_comb begin
    req_grant = '0;
    if (rst && state == IDLE) begin
      req_grant[OWN_IFU] = req_valid[OWN_IFU] && (!req_valid[OWN_LSU] || last_grant == OWN_LSU);
      req_grant[OWN_LSU] = req_valid[OWN_LSU] && (!req_valid[OWN_IFU] || last_grant == OWN_IFU);
    end
  end

  always_comb begin
    new_req = '0;
    if (req_grant[OWN_LSU]) begin
      new_req.owner = OWN_LSU;
      new_req.addr  = lsu_addr;
      new_req.wen   = lsu_wen;
      new_req.wdata = lsu_wen ? lsu_wdata : '0;
      new_req.wmask = lsu_wen ? lsu_wmask : 4'b0000;
    end else begin
      new_req.owner = OWN_IFU;
      new_req.addr  = ifu_addr;
    end
  end

  assign resp_done = resp_ready[cur.owner];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      cur              <= '0;
      last_grant       <= OWN_LSU;
      tmo_cnt          <= '0;
      rdata_q          <= '0;
      err_q            <= 1'b0;
      mem_req_valid_q  <= 1'b0;
      mem_resp_ready_q <= 1'b0;
      resp_valid_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_grant) begin
            cur             <= new_req;
            last_grant      <= new_req.owner;
            mem_req_valid_q <= 1'b1;
            state           <= REQ;
          end
        end
        REQ: begin
          if (mem_req_ready) begin
            mem_req_valid_q  <= 1'b0;
            mem_resp_ready_q <= 1'b1;
            tmo_cnt          <= '0;
            state            <= RESP;
          end
        end
        RESP: begin
          tmo_cnt <= tmo_cnt + 8'd1;
          // A response arriving on the timeout cycle still counts as good data.
          if (mem_resp_valid || tmo_cnt == TMO_LAST) begin
            mem_resp_ready_q        <= 1'b0;
            rdata_q                 <= (mem_resp_valid && !cur.wen) ? mem_rdata : '0;
            err_q                   <= !mem_resp_valid;
            resp_valid_q[cur.owner] <= 1'b1;
            state                   <= DELIVER;
          end
        end
        DELIVER: begin
          if (resp_done) begin
            resp_valid_q <= '0;
            rdata_q      <= '0;
            err_q        <= 1'b0;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ifu_req_ready  = req_grant[OWN_IFU];
  assign lsu_req_ready  = req_grant[OWN_LSU];
  assign ifu_resp_valid = resp_valid_q[OWN_IFU];
  assign lsu_resp_valid = resp_valid_q[OWN_LSU];
  assign ifu_rdata      = resp_valid_q[OWN_IFU] ? rdata_q : '0;
  assign lsu_rdata      = resp_valid_q[OWN_LSU] ? rdata_q : '0;
  assign resp_err       = err_q;

  assign mem_req_valid  = mem_req_valid_q;
  assign mem_resp_ready = mem_resp_ready_q;
  assign mem_addr       = cur.addr;
  assign mem_wen        = cur.wen;
  assign mem_wdata      = cur.wdata;
  assign mem_wmask      = cur.wmask;

  a_one_grant: assert property (@(posedge clk) disable iff (!rst)
    !(ifu_req_ready && lsu_req_ready));
  a_req_stable: assert property (@(posedge clk) disable iff (!rst)
    (mem_req_valid && !mem_req_ready) |=> (mem_req_valid && $stable(mem_addr)
                                           && $stable(mem_wdata) && $stable(mem_wmask)));
  a_one_resp: assert property (@(posedge clk) disable iff (!rst)
    !(ifu_resp_valid && lsu_resp_valid));

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: scripted memory responder plus per-scenario tasks.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ifu_req_valid = 1'b0, ifu_req_ready, ifu_resp_valid, ifu_resp_ready = 1'b0;
  logic [31:0] ifu_addr = '0, ifu_rdata;
  logic        lsu_req_valid = 1'b0, lsu_req_ready, lsu_wen = 1'b0, lsu_resp_valid, lsu_resp_ready = 1'b0;
  logic [31:0] lsu_addr = '0, lsu_wdata = '0, lsu_rdata;
  logic [3:0]  lsu_wmask = '0;
  logic        resp_err;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid, mem_resp_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;

  int checks = 0, errors = 0;

  // memory model controls
  int          req_delay = 0, resp_delay = 0;
  bit          resp_none = 1'b0, force_rvalid = 1'b0;
  logic [31:0] resp_data = '0;
  int          rcnt = 0, pcnt = 0;

  // monitor accumulators (only the monitor writes these)
  int          ifu_rr_cnt = 0, both_hi = 0, resp_cycles = 0, req_cycles = 0, unstable = 0;
  int          ifu_rv_seen = 0, lsu_rv_seen = 0;
  int          grant_log[$];
  logic [31:0] cap_addr = '0, cap_wdata = '0, prev_addr = '0, prev_wdata = '0;
  logic [3:0]  cap_wmask = '0, prev_wmask = '0;
  logic        cap_wen = 1'b0, prev_pend = 1'b0;

  mem_arbiter #(.DATA_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_resp_ready(ifu_resp_ready), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_resp_ready(lsu_resp_ready), .lsu_rdata(lsu_rdata),
    .resp_err(resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory: accepts after req_delay stalled cycles, answers after resp_delay RESP cycles.
  initial begin
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_rdata = '0;
    forever begin
      @(posedge clk); #2;
      mem_rdata = resp_data;
      if (!rst) begin
        mem_req_ready = 1'b0; mem_resp_valid = 1'b0; rcnt = 0; pcnt = 0;
      end else begin
        mem_req_ready  = mem_req_valid && (rcnt == req_delay);
        rcnt           = mem_req_valid ? rcnt + 1 : 0;
        mem_resp_valid = force_rvalid || (mem_resp_ready && !resp_none && pcnt == resp_delay);
        pcnt           = mem_resp_ready ? pcnt + 1 : 0;
      end
    end
  end

  always @(negedge clk) begin
    if (ifu_req_ready) begin ifu_rr_cnt++; grant_log.push_back(0); end
    if (lsu_req_ready) grant_log.push_back(1);
    if (ifu_req_ready && lsu_req_ready) both_hi++;
    if (mem_resp_ready) resp_cycles++;
    if (mem_req_valid) req_cycles++;
    if (mem_req_valid && prev_pend &&
        (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wmask !== prev_wmask)) unstable++;
    prev_pend  = mem_req_valid && !mem_req_ready;
    prev_addr  = mem_addr; prev_wdata = mem_wdata; prev_wmask = mem_wmask;
    if (mem_req_valid && mem_req_ready) begin
      cap_addr = mem_addr; cap_wdata = mem_wdata; cap_wmask = mem_wmask; cap_wen = mem_wen;
    end
    if (ifu_resp_valid) ifu_rv_seen++;
    if (lsu_resp_valid) lsu_rv_seen++;
  end

  task automatic wait_rv(input bit lsu, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(posedge clk); #1;
      if (lsu ? lsu_resp_valid : ifu_resp_valid) ok = 1'b1;
    end
  endtask

  task automatic ack(input bit lsu);
    if (lsu) lsu_resp_ready = 1'b1; else ifu_resp_ready = 1'b1;
    @(posedge clk); #1;
    lsu_resp_ready = 1'b0; ifu_resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] obs;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    obs = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready,
           ifu_resp_valid, lsu_resp_valid, resp_err, mem_wen};
    checks++; if (obs !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b exp 00000000", obs); end
    checks++; if ((mem_addr | mem_wdata | ifu_rdata | lsu_rdata) !== 32'h0 || mem_wmask !== 4'h0) begin
      errors++; $display("FAIL reset_data: addr %h wdata %h wmask %h", mem_addr, mem_wdata, mem_wmask); end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_ifu_read();
    bit ok; int rr0, lrv0;
    req_delay = 0; resp_delay = 2; resp_data = 32'h0000_0413; resp_none = 1'b0;
    rr0 = ifu_rr_cnt; lrv0 = lsu_rv_seen;
    ifu_addr = 32'h8000_0000; ifu_req_valid = 1'b1; #1;
    checks++; if (ifu_req_ready !== 1'b1) begin errors++; $display("FAIL ifu_req_ready: got %b exp 1", ifu_req_ready); end
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    wait_rv(1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL ifu_resp_timeout: got %b exp 1", ok); end
    checks++; if (ifu_rdata !== 32'h0000_0413) begin errors++; $display("FAIL ifu_rdata: got %h exp 00000413", ifu_rdata); end
    checks++; if (resp_err !== 1'b0) begin errors++; $display("FAIL ifu_err: got %b exp 0", resp_err); end
    checks++; if (cap_addr !== 32'h8000_0000 || cap_wmask !== 4'h0 || cap_wen !== 1'b0) begin
      errors++; $display("FAIL ifu_mem_req: addr %h wmask %h wen %b", cap_addr, cap_wmask, cap_wen); end
    checks++; if (ifu_rr_cnt - rr0 !== 1) begin errors++; $display("FAIL ifu_ready_pulses: got %0d exp 1", ifu_rr_cnt - rr0); end
    checks++; if (lsu_rv_seen !== lrv0) begin errors++; $display("FAIL lsu_resp_spurious: got %0d exp %0d", lsu_rv_seen, lrv0); end
    ack(1'b0);
  endtask

  task automatic test_latency();
    req_delay = 0; resp_delay = 0; resp_data = 32'h1111_2222;
    ifu_addr = 32'h8000_0004; ifu_req_valid = 1'b1;
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL lat_c1: got %b exp 0", ifu_resp_valid); end
    @(posedge clk); #1;
    checks++; if (ifu_resp_valid !== 1'b0) begin errors++; $display("FAIL lat_c2: got %b exp 0", ifu_resp_valid); end
    @(posedge clk); #1;
    checks++; if (ifu_resp_valid !== 1'b1 || ifu_rdata !== 32'h1111_2222) begin
      errors++; $display("FAIL lat_c3: valid %b data %h exp 1 11112222", ifu_resp_valid, ifu_rdata); end
    ack(1'b0);
  endtask

  task automatic test_lsu_write();
    bit ok;
    req_delay = 0; resp_delay = 1; resp_data = 32'h1234_5678;
    lsu_addr = 32'h8000_1000; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'b0011; lsu_wen = 1'b1;
    lsu_req_valid = 1'b1; #1;
    checks++; if ({lsu_req_ready, ifu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL lsu_grant: got %b exp 10", {lsu_req_ready, ifu_req_ready}); end
    @(posedge clk); #1; lsu_req_valid = 1'b0;
    wait_rv(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lsu_resp_timeout: got %b exp 1", ok); end
    checks++; if (cap_wen !== 1'b1 || cap_wdata !== 32'hDEAD_BEEF || cap_wmask !== 4'b0011 || cap_addr !== 32'h8000_1000) begin
      errors++; $display("FAIL lsu_mem_req: wen %b wdata %h wmask %h addr %h", cap_wen, cap_wdata, cap_wmask, cap_addr); end
    checks++; if (lsu_rdata !== 32'h0 || resp_err !== 1'b0 || ifu_resp_valid !== 1'b0) begin
      errors++; $display("FAIL lsu_wr_resp: rdata %h err %b ifu_v %b exp 0 0 0", lsu_rdata, resp_err, ifu_resp_valid); end
    ack(1'b1);
    lsu_wen = 1'b0;
  endtask

  task automatic test_round_robin();
    int g0, bh0, n;
    int exp_g[4] = '{0, 1, 0, 1};
    req_delay = 0; resp_delay = 0;
    g0 = grant_log.size(); bh0 = both_hi;
    ifu_addr = 32'h0000_0040; lsu_addr = 32'h0000_0080; lsu_wen = 1'b0; lsu_wmask = 4'hF;
    ifu_resp_ready = 1'b1; lsu_resp_ready = 1'b1;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1;
    for (int i = 0; i < 100 && grant_log.size() - g0 < 4; i++) begin @(posedge clk); #1; end
    ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1; ifu_resp_ready = 1'b0; lsu_resp_ready = 1'b0;
    n = grant_log.size() - g0;
    checks++; if (n !== 4) begin errors++; $display("FAIL rr_count: got %0d exp 4", n); end
    for (int i = 0; i < 4 && i < n; i++) begin
      checks++; if (grant_log[g0 + i] !== exp_g[i]) begin
        errors++; $display("FAIL rr_grant%0d: got %0d exp %0d", i, grant_log[g0 + i], exp_g[i]); end
    end
    checks++; if (both_hi - bh0 !== 0) begin errors++; $display("FAIL rr_both_ready: got %0d exp 0", both_hi - bh0); end
    checks++; if (cap_wmask !== 4'h0) begin errors++; $display("FAIL rr_read_wmask: got %h exp 0", cap_wmask); end
  endtask

  task automatic test_timeout();
    bit ok; int rc0;
    resp_none = 1'b1; resp_data = 32'hAAAA_5555;
    rc0 = resp_cycles;
    ifu_addr = 32'h0000_0100; ifu_req_valid = 1'b1;
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    wait_rv(1'b0, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL tmo_wait: got %b exp 1", ok); end
    checks++; if (resp_cycles - rc0 !== 8) begin errors++; $display("FAIL tmo_cycles: got %0d exp 8", resp_cycles - rc0); end
    checks++; if (resp_err !== 1'b1 || ifu_rdata !== 32'h0) begin
      errors++; $display("FAIL tmo_resp: err %b rdata %h exp 1 0", resp_err, ifu_rdata); end
    ack(1'b0);
    resp_none = 1'b0; resp_delay = 0; resp_data = 32'h0BAD_F00D;
    lsu_addr = 32'h0000_0200; lsu_wen = 1'b0; lsu_req_valid = 1'b1;
    @(posedge clk); #1; lsu_req_valid = 1'b0;
    wait_rv(1'b1, ok);
    checks++; if (ok !== 1'b1 || lsu_rdata !== 32'h0BAD_F00D || resp_err !== 1'b0) begin
      errors++; $display("FAIL tmo_next: ok %b rdata %h err %b exp 1 0badf00d 0", ok, lsu_rdata, resp_err); end
    ack(1'b1);
  endtask

  task automatic test_req_stall();
    bit ok; int rq0, un0, rc0;
    req_delay = 5; resp_delay = 0;
    rq0 = req_cycles; un0 = unstable; rc0 = resp_cycles;
    lsu_addr = 32'h0000_3000; lsu_wdata = 32'hCAFE_F00D; lsu_wmask = 4'b1100; lsu_wen = 1'b1;
    lsu_req_valid = 1'b1;
    @(posedge clk); #1; lsu_req_valid = 1'b0;
    wait_rv(1'b1, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL stall_wait: got %b exp 1", ok); end
    checks++; if (req_cycles - rq0 !== 6) begin errors++; $display("FAIL stall_req_cycles: got %0d exp 6", req_cycles - rq0); end
    checks++; if (unstable - un0 !== 0) begin errors++; $display("FAIL stall_stable: got %0d exp 0", unstable - un0); end
    checks++; if (resp_cycles - rc0 !== 1 || resp_err !== 1'b0) begin
      errors++; $display("FAIL stall_resp: cycles %0d err %b exp 1 0", resp_cycles - rc0, resp_err); end
    checks++; if (cap_wdata !== 32'hCAFE_F00D || cap_wmask !== 4'b1100) begin
      errors++; $display("FAIL stall_data: wdata %h wmask %h", cap_wdata, cap_wmask); end
    ack(1'b1);
    req_delay = 0; lsu_wen = 1'b0;
  endtask

  task automatic test_async_reset();
    bit ok; int rv0;
    logic [6:0] obs;
    resp_none = 1'b1;
    ifu_addr = 32'h0000_0400; ifu_req_valid = 1'b1;
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin @(posedge clk); #1; if (mem_resp_ready) ok = 1'b1; end
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL arst_reach_resp: got %b exp 1", ok); end
    @(posedge clk);
    @(negedge clk); #1;
    rst = 1'b0; ifu_req_valid = 1'b1; #1;
    obs = {ifu_req_ready, lsu_req_ready, mem_req_valid, mem_resp_ready, ifu_resp_valid, lsu_resp_valid, resp_err};
    checks++; if (obs !== 7'h00) begin errors++; $display("FAIL arst_ctrl: got %b exp 0000000", obs); end
    checks++; if (mem_addr !== 32'h0) begin errors++; $display("FAIL arst_addr: got %h exp 0", mem_addr); end
    @(posedge clk); #1; ifu_req_valid = 1'b0;
    @(negedge clk); rst = 1'b1; resp_none = 1'b0; force_rvalid = 1'b1;
    rv0 = ifu_rv_seen + lsu_rv_seen;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (ifu_rv_seen + lsu_rv_seen !== rv0 || mem_resp_ready !== 1'b0) begin
      errors++; $display("FAIL arst_late_resp: resp %0d ready %b exp %0d 0", ifu_rv_seen + lsu_rv_seen, mem_resp_ready, rv0); end
    force_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resp_delay = 0; resp_data = 32'h5A5A_0001;
    ifu_addr = 32'h0000_0500; lsu_addr = 32'h0000_0600;
    ifu_req_valid = 1'b1; lsu_req_valid = 1'b1; #1;
    checks++; if ({ifu_req_ready, lsu_req_ready} !== 2'b10) begin
      errors++; $display("FAIL arst_first_tie: got %b exp 10", {ifu_req_ready, lsu_req_ready}); end
    @(posedge clk); #1; ifu_req_valid = 1'b0; lsu_req_valid = 1'b0;
    wait_rv(1'b0, ok);
    checks++; if (ok !== 1'b1 || ifu_rdata !== 32'h5A5A_0001) begin
      errors++; $display("FAIL arst_after: ok %b rdata %h exp 1 5a5a0001", ok, ifu_rdata); end
    ack(1'b0);
  endtask

  initial begin
    test_reset();
    test_ifu_read();
    test_latency();
    test_lsu_write();
    test_round_robin();
    test_timeout();
    test_req_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
